// File: rtl/spi_master_3wire_param.sv
// Half-duplex 3-wire SPI master: write phase, optional turnaround and read phase on one shared
// data line, with programmable SCLK divider, clock polarity and chip-select count.
module spi_master_3wire_param #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned NUM_CS   = 4,
    parameter int unsigned CS_IDX_W = 2,
    parameter bit          CPOL     = 1'b0,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                rd,
    input  logic [CS_IDX_W-1:0] cs_sel,
    input  logic [DATA_W-1:0]   tx_data,
    output logic                busy,
    output logic [DATA_W-1:0]   rx_data,
    output logic                rx_valid,
    output logic                spi_clk,
    output logic [NUM_CS-1:0]   spi_cs_n,
    output logic                spi_io_o,
    output logic                spi_io_oe,
    input  logic                spi_io_i
);
    localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);
    localparam int unsigned HALF_W = $clog2(2 * DATA_W + 2 * TURN_CYC + 1);
    localparam int unsigned CSW1   = CS_IDX_W + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] DATA_LAST = HALF_W'(2 * DATA_W - 1);
    localparam logic [HALF_W-1:0] TURN_LAST = HALF_W'(2 * TURN_CYC - 1);
    localparam logic [CSW1-1:0]   NUM_CS_W  = CSW1'(NUM_CS);

    typedef enum logic [2:0] {StIdle, StSetup, StTx, StTurn, StRx, StHold} state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q;
    logic [HALF_W-1:0]   half_q, half_last;
    logic                tick, phase_done, accept;
    logic [DATA_W-1:0]   tx_sh_q, rx_sh_q, rx_data_q;
    logic                rd_q, sclk_q, rx_valid_q;
    logic [NUM_CS-1:0]   cs_n_q, cs_onehot;

    always_comb begin
        cs_onehot = '0;
        for (int i = 0; i < int'(NUM_CS); i++) begin
            cs_onehot[i] = (cs_sel == CS_IDX_W'(i));
        end
    end

    // Each phase lasts a whole number of half-periods; half_last is the final half-period index.
    always_comb begin
        half_last = '0;
        case (state_q)
            StTx, StRx: half_last = DATA_LAST;
            StTurn:     half_last = TURN_LAST;
            default:    half_last = '0;
        endcase
    end

    assign tick       = (state_q != StIdle) && (div_q == DIV_LAST);
    assign phase_done = tick && (half_q == half_last);
    assign accept     = (state_q == StIdle) && start && ({1'b0, cs_sel} < NUM_CS_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept)     state_d = StSetup;
            StSetup: if (phase_done) state_d = StTx;
            StTx:    if (phase_done) state_d = rd_q ? StTurn : StHold;
            StTurn:  if (phase_done) state_d = StRx;
            StRx:    if (phase_done) state_d = StHold;
            StHold:  if (phase_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        spi_io_oe = (state_q == StSetup) || (state_q == StTx);
        spi_io_o  = tx_sh_q[DATA_W-1];
        spi_clk   = sclk_q;
        spi_cs_n  = cs_n_q;
        rx_data   = rx_data_q;
        rx_valid  = rx_valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            half_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_q       <= 1'b0;
            sclk_q     <= CPOL;
            cs_n_q     <= '1;
        end else begin
            rx_valid_q <= 1'b0;
            div_q      <= (state_q == StIdle || tick) ? '0 : div_q + DIV_W'(1);
            if (state_q != state_d) begin
                half_q <= '0;
            end else if (tick) begin
                half_q <= half_q + HALF_W'(1);
            end
            if (accept) begin
                tx_sh_q <= tx_data;
                rd_q    <= rd;
                cs_n_q  <= ~cs_onehot;
            end
            if (tick && (state_q == StTx || state_q == StRx)) begin
                sclk_q <= ~sclk_q;
            end
            // Odd half-period ends on a trailing edge (launch), even on a leading edge (sample).
            if (tick && state_q == StTx && half_q[0]) begin
                tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
            end
            if (tick && state_q == StRx && !half_q[0]) begin
                rx_sh_q <= {rx_sh_q[DATA_W-2:0], spi_io_i};
            end
            if (state_q == StHold && phase_done) begin
                cs_n_q <= '1;
                if (rd_q) begin
                    rx_data_q  <= rx_sh_q;
                    rx_valid_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_3wire_param.sv
// Directed bench: a 16-bit CPOL=0 master with a behavioural slave, plus an 8-bit CPOL=1 variant.
module tb_spi_master_3wire_param;
    localparam bit ACPOL = 1'b0;
    localparam bit BCPOL = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: DATA_W 16, CLK_DIV 4, NUM_CS 4, CS_IDX_W 3, CPOL 0, TURN_CYC 1
    logic        a_start = 1'b0, a_rd = 1'b0;
    logic [2:0]  a_cs = '0;
    logic [15:0] a_tx = '0;
    logic        a_busy, a_rxv, a_sclk, a_io_o, a_oe, a_io_i;
    logic [15:0] a_rxd;
    logic [3:0]  a_cs_n;

    // DUT B: DATA_W 8, CLK_DIV 1, NUM_CS 2, CS_IDX_W 1, CPOL 1, TURN_CYC 2
    logic        b_start = 1'b0, b_rd = 1'b0;
    logic [0:0]  b_cs = '0;
    logic [7:0]  b_tx = '0;
    logic        b_busy, b_rxv, b_sclk, b_io_o, b_oe, b_io_i;
    logic [7:0]  b_rxd;
    logic [1:0]  b_cs_n;

    spi_master_3wire_param #(
        .DATA_W(16), .CLK_DIV(4), .NUM_CS(4), .CS_IDX_W(3), .CPOL(ACPOL), .TURN_CYC(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .rd(a_rd), .cs_sel(a_cs), .tx_data(a_tx),
        .busy(a_busy), .rx_data(a_rxd), .rx_valid(a_rxv), .spi_clk(a_sclk),
        .spi_cs_n(a_cs_n), .spi_io_o(a_io_o), .spi_io_oe(a_oe), .spi_io_i(a_io_i)
    );

    spi_master_3wire_param #(
        .DATA_W(8), .CLK_DIV(1), .NUM_CS(2), .CS_IDX_W(1), .CPOL(BCPOL), .TURN_CYC(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .rd(b_rd), .cs_sel(b_cs), .tx_data(b_tx),
        .busy(b_busy), .rx_data(b_rxd), .rx_valid(b_rxv), .spi_clk(b_sclk),
        .spi_cs_n(b_cs_n), .spi_io_o(b_io_o), .spi_io_oe(b_oe), .spi_io_i(b_io_i)
    );

    // Bus monitors / slave models, sampled on the falling clk edge.
    logic [15:0] a_rdata = '0, a_sh;
    logic [7:0]  b_rdata = '0, b_sh;
    logic [31:0] a_txcap = '0, b_txcap = '0;
    logic        a_sclk_p = ACPOL, a_oe_p = 1'b0, b_sclk_p = BCPOL, b_oe_p = 1'b0;
    int unsigned a_ridx = 0, a_txn = 0, a_bcnt = 0, a_oel = 0, a_rv = 0, a_tog = 0;
    int unsigned b_ridx = 0, b_txn = 0, b_bcnt = 0, b_rv = 0, b_tog = 0;

    always_comb begin
        a_sh   = a_rdata << a_ridx;
        a_io_i = !a_oe ? a_sh[15] : 1'b0;
        b_sh   = b_rdata << b_ridx;
        b_io_i = !b_oe ? b_sh[7] : 1'b0;
    end

    always @(negedge clk) begin
        a_sclk_p <= a_sclk;
        a_oe_p   <= a_oe;
        if (a_sclk != a_sclk_p) a_tog <= a_tog + 1;
        if (a_sclk_p == ACPOL && a_sclk != ACPOL && a_oe) begin
            a_txcap <= {a_txcap[30:0], a_io_o};
            a_txn   <= a_txn + 1;
        end
        if (a_cs_n == 4'hF) a_ridx <= 0;
        else if (a_sclk_p != ACPOL && a_sclk == ACPOL && !a_oe_p) a_ridx <= a_ridx + 1;
        if (a_busy) a_bcnt <= a_bcnt + 1;
        if (a_busy && !a_oe) a_oel <= a_oel + 1;
        if (a_rxv) a_rv <= a_rv + 1;
    end

    always @(negedge clk) begin
        b_sclk_p <= b_sclk;
        b_oe_p   <= b_oe;
        if (b_sclk != b_sclk_p) b_tog <= b_tog + 1;
        if (b_sclk_p == BCPOL && b_sclk != BCPOL && b_oe) begin
            b_txcap <= {b_txcap[30:0], b_io_o};
            b_txn   <= b_txn + 1;
        end
        if (b_cs_n == 2'b11) b_ridx <= 0;
        else if (b_sclk_p != BCPOL && b_sclk == BCPOL && !b_oe_p) b_ridx <= b_ridx + 1;
        if (b_busy) b_bcnt <= b_bcnt + 1;
        if (b_rxv) b_rv <= b_rv + 1;
    end

    int n_cmp = 0;
    int n_err = 0;
    int unsigned s_bcnt, s_txn, s_oel, s_rv, s_tog;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic snap_a();
        s_bcnt = a_bcnt; s_txn = a_txn; s_oel = a_oel; s_rv = a_rv; s_tog = a_tog;
    endtask

    task automatic start_a(input logic [15:0] d, input logic r, input logic [2:0] cs);
        a_tx = d; a_rd = r; a_cs = cs; a_start = 1'b1;
        step();
        a_start = 1'b0;
    endtask

    task automatic wait_a(input string tag);
        int g = 0;
        while (a_busy && g < 2000) begin step(); g++; end
        check(tag, 32'(a_busy), 32'h0);
    endtask

    task automatic wait_b(input string tag);
        int g = 0;
        while (b_busy && g < 2000) begin step(); g++; end
        check(tag, 32'(b_busy), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_cs_n", 32'(a_cs_n), 32'hF);
        check("rst_sclk", 32'(a_sclk), 32'h0);
        check("rst_oe", 32'(a_oe), 32'h0);
        check("rst_io_o", 32'(a_io_o), 32'h0);
        check("rst_busy", 32'(a_busy), 32'h0);
        check("rst_rxv", 32'(a_rxv), 32'h0);
        check("rst_rxd", 32'(a_rxd), 32'h0);
        check("rst_b_sclk", 32'(b_sclk), 32'h1);
        check("rst_b_cs_n", 32'(b_cs_n), 32'h3);
        rst = 1'b0;
        repeat (2) step();

        // Write A5C3 to slave 2
        snap_a();
        start_a(16'hA5C3, 1'b0, 3'd2);
        check("wr_cs_n", 32'(a_cs_n), 32'hB);
        check("wr_busy1", 32'(a_busy), 32'h1);
        check("wr_oe", 32'(a_oe), 32'h1);
        check("wr_io_msb", 32'(a_io_o), 32'h1);
        wait_a("wr_done");
        check("wr_busy_cycles", a_bcnt - s_bcnt, 32'd136);
        check("wr_bits", a_txn - s_txn, 32'd16);
        check("wr_word", 32'(a_txcap[15:0]), 32'hA5C3);
        check("wr_oe_low", a_oel - s_oel, 32'd4);
        check("wr_cs_idle", 32'(a_cs_n), 32'hF);
        check("wr_rxd_kept", 32'(a_rxd), 32'h0);
        check("wr_no_rxv", a_rv - s_rv, 32'd0);

        // Read: write 8001 to slave 1, slave answers 3C5A
        a_rdata = 16'h3C5A;
        snap_a();
        start_a(16'h8001, 1'b1, 3'd1);
        check("rd_cs_n", 32'(a_cs_n), 32'hD);
        wait_a("rd_done");
        check("rd_rxv_pulse", 32'(a_rxv), 32'h1);
        check("rd_rxd", 32'(a_rxd), 32'h3C5A);
        step();
        check("rd_rxv_low", 32'(a_rxv), 32'h0);
        check("rd_busy_cycles", a_bcnt - s_bcnt, 32'd272);
        check("rd_word_out", 32'(a_txcap[15:0]), 32'h8001);
        check("rd_oe_low", a_oel - s_oel, 32'd140);
        check("rd_toggles", a_tog - s_tog, 32'd64);
        check("rd_rxv_count", a_rv - s_rv, 32'd1);

        // Out-of-range select and start-while-busy are ignored
        a_tx = 16'hFFFF; a_cs = 3'd5; a_rd = 1'b0; a_start = 1'b1;
        step();
        a_start = 1'b0;
        check("bad_cs_busy", 32'(a_busy), 32'h0);
        check("bad_cs_cs_n", 32'(a_cs_n), 32'hF);
        step();
        snap_a();
        start_a(16'h1234, 1'b0, 3'd0);
        repeat (20) step();
        a_tx = 16'hFFFF; a_cs = 3'd3; a_rd = 1'b1; a_start = 1'b1;
        step();
        a_start = 1'b0;
        check("ign_cs_n", 32'(a_cs_n), 32'hE);
        wait_a("ign_done");
        check("ign_busy_cycles", a_bcnt - s_bcnt, 32'd136);
        check("ign_word", 32'(a_txcap[15:0]), 32'h1234);
        check("ign_rxd_kept", 32'(a_rxd), 32'h3C5A);
        check("ign_no_rxv", a_rv - s_rv, 32'd0);
        step();

        // Back-to-back with start held high
        snap_a();
        a_tx = 16'h0F0F; a_cs = 3'd3; a_rd = 1'b0; a_start = 1'b1;
        step();
        check("b2b_cs_n1", 32'(a_cs_n), 32'h7);
        wait_a("b2b_done1");
        check("b2b_gap_cs", 32'(a_cs_n), 32'hF);
        check("b2b_word1", 32'(a_txcap[15:0]), 32'h0F0F);
        check("b2b_busy1", a_bcnt - s_bcnt, 32'd136);
        a_tx = 16'hF0F0;
        snap_a();
        step();
        a_start = 1'b0;
        check("b2b_restart", 32'(a_busy), 32'h1);
        check("b2b_cs_n2", 32'(a_cs_n), 32'h7);
        wait_a("b2b_done2");
        check("b2b_word2", 32'(a_txcap[15:0]), 32'hF0F0);
        check("b2b_busy2", a_bcnt - s_bcnt, 32'd136);
        step();

        // Variant: CLK_DIV 1, CPOL 1, DATA_W 8, TURN_CYC 2, read 96
        b_rdata = 8'h96;
        s_bcnt = b_bcnt; s_txn = b_txn; s_rv = b_rv; s_tog = b_tog;
        b_tx = 8'h3C; b_rd = 1'b1; b_cs = 1'b1; b_start = 1'b1;
        step();
        b_start = 1'b0;
        check("b_cs_n", 32'(b_cs_n), 32'h1);
        check("b_sclk_idle", 32'(b_sclk), 32'h1);
        wait_b("b_done");
        check("b_rxv_pulse", 32'(b_rxv), 32'h1);
        check("b_rxd", 32'(b_rxd), 32'h96);
        step();
        check("b_busy_cycles", b_bcnt - s_bcnt, 32'd38);
        check("b_bits", b_txn - s_txn, 32'd8);
        check("b_word_out", 32'(b_txcap[7:0]), 32'h3C);
        check("b_toggles", b_tog - s_tog, 32'd32);
        check("b_rxv_count", b_rv - s_rv, 32'd1);
        check("b_sclk_end", 32'(b_sclk), 32'h1);

        // Asynchronous reset in the middle of TX while SCLK is high
        snap_a();
        start_a(16'hFFFF, 1'b1, 3'd0);
        repeat (40) step();
        check("mid_sclk_high", 32'(a_sclk), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_cs_n", 32'(a_cs_n), 32'hF);
        check("mid_rst_sclk", 32'(a_sclk), 32'h0);
        check("mid_rst_oe", 32'(a_oe), 32'h0);
        check("mid_rst_busy", 32'(a_busy), 32'h0);
        check("mid_rst_rxv", 32'(a_rxv), 32'h0);
        check("mid_rst_rxd", 32'(a_rxd), 32'h0);
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        check("post_rst_busy", 32'(a_busy), 32'h0);
        check("post_rst_no_rxv", a_rv - s_rv, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
